// File: rtl/accel_mailbox_pkg.sv
// Shared types and constants for the accelerator mailbox.
// Latency: none (declarations only).
// Backpressure: not applicable.
package accel_mailbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mbox_state_t;

  localparam logic [31:0] STATUS_BUSY    = 32'h0000_0000;
  localparam logic [31:0] STATUS_IDLE    = 32'h8000_0000;
  localparam logic [31:0] STATUS_TIMEOUT = 32'h0000_0001;

  localparam int GO_BIT = 31;

endpackage

// File: rtl/accel_mailbox_wdt.sv
// Job watchdog: counts cycles while a job is outstanding, flags expiry.
// Latency: expired is combinational on the count, high in the TIMEOUT_CYCLES-th busy cycle.
// Backpressure: none; clear has priority over enable.
// Ports: clk/rst (sync, active high), clear_i zeroes the count, enable_i counts,
//        expired_o high when the enabled count reaches TIMEOUT_CYCLES-1.
module accel_mailbox_wdt #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count is 0 after the edge that enters REQ, so reaching
  // TIMEOUT_CYCLES-1 here means the next edge is TIMEOUT_CYCLES after entry.
  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/accel_mailbox.sv
// Accelerator mailbox: turns GO rises on the x1 mirror into accelerator jobs and reports status.
// Latency: GO rise at edge n -> request and busy status after edge n; response at edge m -> done status after edge m.
// Backpressure: request held (arg stable) until acc_req_ready; response accepted whenever not in REQ.
// Ports: cmd_word (GO bit 31 + arg), status_word (0 busy / bit31 done / else error),
//        acc_req_* request channel, acc_rsp_* response channel, busy (REQ or WAIT).
// Optional watchdog enabled by defining ACCEL_MAILBOX_TIMEOUT_EN.
module accel_mailbox
  import accel_mailbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_word,
  output logic [31:0] status_word,
  output logic        acc_req_valid,
  input  logic        acc_req_ready,
  output logic [30:0] acc_req_arg,
  input  logic        acc_rsp_valid,
  output logic        acc_rsp_ready,
  input  logic [30:0] acc_rsp_data,
  output logic        busy
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
    $error("accel_mailbox: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  mbox_state_t state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [30:0] arg_q, arg_d;
  logic        go_q;
  logic        go_rise;
  logic        wdt_expired;

  assign go_rise = cmd_word[GO_BIT] & ~go_q;

`ifdef ACCEL_MAILBOX_TIMEOUT_EN
  accel_mailbox_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE),
    .enable_i (state_q == REQ || state_q == WAIT),
    .expired_o(wdt_expired)
  );
`else
  assign wdt_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    arg_d    = arg_q;
    unique case (state_q)
      IDLE: begin
        if (go_rise) begin
          arg_d    = cmd_word[30:0];
          status_d = STATUS_BUSY;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (wdt_expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = IDLE;
        end else if (acc_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the expiry edge still counts as done.
        if (acc_rsp_valid) begin
          status_d = {1'b1, acc_rsp_data};
          state_d  = IDLE;
        end else if (wdt_expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= STATUS_IDLE;
      arg_q    <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      arg_q    <= arg_d;
      go_q     <= cmd_word[GO_BIT];
    end
  end

  assign status_word   = status_q;
  assign acc_req_arg   = arg_q;
  assign acc_req_valid = (state_q == REQ);
  assign busy          = (state_q == REQ) || (state_q == WAIT);
  // Responses are drained in IDLE too, so stray results never stall the
  // accelerator; held low while reset is applied.
  assign acc_rsp_ready = ((state_q == IDLE) || (state_q == WAIT)) && !rst;

endmodule

// File: tb/tb_accel_mailbox.sv
module tb_accel_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_word;
  logic [31:0] status_word;
  logic        acc_req_valid;
  logic        acc_req_ready;
  logic [30:0] acc_req_arg;
  logic        acc_rsp_valid;
  logic        acc_rsp_ready;
  logic [30:0] acc_rsp_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accel_mailbox #(
    .TIMEOUT_CYCLES(16),
    .CNT_W         (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_word     (cmd_word),
    .status_word  (status_word),
    .acc_req_valid(acc_req_valid),
    .acc_req_ready(acc_req_ready),
    .acc_req_arg  (acc_req_arg),
    .acc_rsp_valid(acc_rsp_valid),
    .acc_rsp_ready(acc_rsp_ready),
    .acc_rsp_data (acc_rsp_data),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic saw_req;

    rst           = 1'b1;
    cmd_word      = 32'h0;
    acc_req_ready = 1'b0;
    acc_rsp_valid = 1'b0;
    acc_rsp_data  = 31'h0;
    tick();
    tick();
    check_eq("rst_status", status_word, 32'h8000_0000);
    check_eq("rst_req_valid", {31'h0, acc_req_valid}, 32'h0);
    check_eq("rst_rsp_ready", {31'h0, acc_rsp_ready}, 32'h0);
    check_eq("rst_arg", {1'b0, acc_req_arg}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    tick();
    check_eq("idle_rsp_ready", {31'h0, acc_rsp_ready}, 32'h1);

    // Argument bits without GO do nothing.
    cmd_word = 32'h0000_0005;
    saw_req  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_req |= acc_req_valid;
    end
    check_eq("nogo_req", {31'h0, saw_req}, 32'h0);
    check_eq("nogo_status", status_word, 32'h8000_0000);

    // Basic job: ready already high, response 3 edges after the GO rise.
    cmd_word      = 32'h0;
    acc_req_ready = 1'b1;
    tick();
    cmd_word = 32'h8000_0123;
    tick();
    check_eq("basic_status_busy", status_word, 32'h0);
    check_eq("basic_req_valid", {31'h0, acc_req_valid}, 32'h1);
    check_eq("basic_busy", {31'h0, busy}, 32'h1);
    check_eq("basic_arg", {1'b0, acc_req_arg}, 32'h0000_0123);
    tick();
    check_eq("basic_wait_valid", {31'h0, acc_req_valid}, 32'h0);
    check_eq("basic_wait_rsp_rdy", {31'h0, acc_rsp_ready}, 32'h1);
    tick();
    check_eq("basic_wait_status", status_word, 32'h0);
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 31'h456;
    tick();
    acc_rsp_valid = 1'b0;
    check_eq("basic_done_status", status_word, 32'h8000_0456);
    check_eq("basic_done_busy", {31'h0, busy}, 32'h0);

    // GO still high after completion: no second job.
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_req |= acc_req_valid;
    end
    check_eq("held_go_req", {31'h0, saw_req}, 32'h0);

    // Backpressure: ready low for 5 cycles, arg bits changed underneath.
    cmd_word      = 32'h0;
    acc_req_ready = 1'b0;
    tick();
    cmd_word = 32'h8000_0ABC;
    tick();
    cmd_word = 32'h8000_0FFF;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_req_valid", {31'h0, acc_req_valid}, 32'h1);
      check_eq("bp_arg", {1'b0, acc_req_arg}, 32'h0000_0ABC);
      check_eq("bp_status", status_word, 32'h0);
      tick();
    end
    acc_req_ready = 1'b1;
    tick();
    check_eq("bp_in_wait", {31'h0, acc_req_valid}, 32'h0);

    // GO toggled 1->0->1 in WAIT is ignored.
    cmd_word = 32'h0;
    tick();
    cmd_word = 32'h8000_0777;
    tick();
    check_eq("tog_busy", {31'h0, busy}, 32'h1);
    check_eq("tog_req_valid", {31'h0, acc_req_valid}, 32'h0);
    check_eq("tog_arg", {1'b0, acc_req_arg}, 32'h0000_0ABC);

    // Response coincident with a GO rise: response wins, GO rise dropped.
    cmd_word = 32'h0;
    tick();
    cmd_word      = 32'h8000_0111;
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 31'h0123_4567;
    tick();
    acc_rsp_valid = 1'b0;
    check_eq("sim_status", status_word, 32'h8123_4567);
    check_eq("sim_busy", {31'h0, busy}, 32'h0);
    tick();
    check_eq("sim_no_req", {31'h0, acc_req_valid}, 32'h0);

    // Fresh rise in IDLE launches a new job.
    cmd_word = 32'h0;
    tick();
    cmd_word = 32'h8000_0222;
    tick();
    check_eq("fresh_req_valid", {31'h0, acc_req_valid}, 32'h1);
    check_eq("fresh_arg", {1'b0, acc_req_arg}, 32'h0000_0222);
    tick();
    check_eq("fresh_wait_busy", {31'h0, busy}, 32'h1);

    // Reset in WAIT with GO still high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstw_status", status_word, 32'h8000_0000);
    check_eq("rstw_busy", {31'h0, busy}, 32'h0);
    check_eq("rstw_req_valid", {31'h0, acc_req_valid}, 32'h0);
    tick();
    check_eq("rstw_new_req", {31'h0, acc_req_valid}, 32'h1);
    check_eq("rstw_new_arg", {1'b0, acc_req_arg}, 32'h0000_0222);
    tick();
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 31'h55;
    tick();
    acc_rsp_valid = 1'b0;
    check_eq("rstw_done", status_word, 32'h8000_0055);

    // Stray response in IDLE: consumed, status unchanged.
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 31'h99;
    check_eq("stray_rsp_ready", {31'h0, acc_rsp_ready}, 32'h1);
    tick();
    acc_rsp_valid = 1'b0;
    check_eq("stray_status", status_word, 32'h8000_0055);

`ifdef ACCEL_MAILBOX_TIMEOUT_EN
    // Timeout: stuck in REQ, expiry 16 edges after entry.
    cmd_word      = 32'h0;
    acc_req_ready = 1'b0;
    tick();
    cmd_word = 32'h8000_0333;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      check_eq("to_pending", status_word, 32'h0);
    end
    tick();
    check_eq("to_status", status_word, 32'h0000_0001);
    check_eq("to_req_valid", {31'h0, acc_req_valid}, 32'h0);
    check_eq("to_busy", {31'h0, busy}, 32'h0);
    acc_rsp_valid = 1'b1;
    acc_rsp_data  = 31'h7;
    tick();
    acc_rsp_valid = 1'b0;
    check_eq("to_late_rsp", status_word, 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
